// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: default sizing and the buffered-store record
package store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW = 32;
  localparam int SB_DW = 32;
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: store, load-forward and drain signals of the store buffer
interface store_buffer_if #(parameter int DEPTH = 4, parameter int AW = 32, parameter int DW = 32);
  logic                   st_valid;
  logic [AW-1:0]          st_addr;
  logic [DW-1:0]          st_data;
  logic                   st_ready;
  logic [AW-1:0]          ld_addr;
  logic                   ld_hit;
  logic [DW-1:0]          ld_fwd_data;
  logic                   mem_hold;
  logic                   mem_write;
  logic [AW-1:0]          mem_address;
  logic [DW-1:0]          mem_writeData;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_hold,
    input  st_ready, ld_hit, ld_fwd_data, mem_write, mem_address, mem_writeData, empty, count
  );
  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_hold,
    output st_ready, ld_hit, ld_fwd_data, mem_write, mem_address, mem_writeData, empty, count
  );
endinterface

// File: rtl/store_buffer_fwd_match.sv
// sb_fwd_match: youngest-first address match over buffered stores
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_i,
  input  logic [AW-1:0]    addr_i [DEPTH],
  input  logic [DW-1:0]    data_i [DEPTH],
  input  logic [PW-1:0]    wr_ptr_i,
  input  logic [AW-1:0]    ld_addr_i,
  output logic             hit_o,
  output logic [DW-1:0]    data_o
);
  logic [PW-1:0] idx;
  // walk oldest to youngest so the youngest match is the last one written
  always_comb begin
    hit_o = 1'b0;
    data_o = '0;
    idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr_i - PW'(k);
      if (valid_i[idx] && addr_i[idx] == ld_addr_i) begin
        hit_o = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO draining to data memory with load forwarding
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic             push, pop, empty;
  assign empty = count_q == '0;
  assign push = bus.st_valid && bus.st_ready;
  assign pop = bus.mem_write;
  assign bus.st_ready = count_q != CW'(DEPTH);
  assign bus.mem_write = !empty && !bus.mem_hold;
  // head gated so stale array contents never reach the memory bus
  assign bus.mem_address = empty ? '0 : addr_q[rd_ptr_q];
  assign bus.mem_writeData = empty ? '0 : data_q[rd_ptr_q];
  assign bus.empty = empty;
  assign bus.count = count_q;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    valid_d = valid_q;
    if (pop) valid_d[rd_ptr_q] = 1'b0;
    if (push) valid_d[wr_ptr_q] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.st_addr;
      data_q[wr_ptr_q] <= bus.st_data;
    end
  end
  sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
    .valid_i  (valid_q),
    .addr_i   (addr_q),
    .data_i   (data_q),
    .wr_ptr_i (wr_ptr_q),
    .ld_addr_i(bus.ld_addr),
    .hit_o    (bus.ld_hit),
    .data_o   (bus.ld_fwd_data)
  );
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a drain-order scoreboard
module tb_store_buffer;
  import store_buffer_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  sb_entry_t exp_q[$];
  store_buffer_if #(.DEPTH(4), .AW(32), .DW(32)) sb ();
  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(sb.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    sb.st_valid = 1'b1;
    sb.st_addr = a;
    sb.st_data = d;
    @(negedge clk);
    while (!sb.st_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("push_ready", 64'(sb.st_ready), 64'd1);
    @(posedge clk);
    #1;
    sb.st_valid = 1'b0;
    if (n < 20) exp_q.push_back('{addr: a, data: d});
  endtask
  task automatic wait_empty();
    for (int n = 0; n < 40 && !sb.empty; n++) tick();
    chk("drain_empty", 64'(sb.empty), 64'd1);
  endtask
  always @(negedge clk) begin
    if (rst_n && sb.mem_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write got addr=%0h data=%0h exp none", sb.mem_address, sb.mem_writeData);
      end else begin
        sb_entry_t e;
        e = exp_q.pop_front();
        chk("drain_addr", 64'(sb.mem_address), 64'(e.addr));
        chk("drain_data", 64'(sb.mem_writeData), 64'(e.data));
      end
    end
  end
  initial begin
    sb.st_valid = 1'b0;
    sb.st_addr = '0;
    sb.st_data = '0;
    sb.ld_addr = '0;
    sb.mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(sb.st_ready), 64'd1);
    chk("rst_empty", 64'(sb.empty), 64'd1);
    chk("rst_count", 64'(sb.count), 64'd0);
    chk("rst_mem_write", 64'(sb.mem_write), 64'd0);
    chk("rst_ld_hit", 64'(sb.ld_hit), 64'd0);
    chk("rst_fwd_data", 64'(sb.ld_fwd_data), 64'd0);
    chk("rst_mem_addr", 64'(sb.mem_address), 64'd0);
    chk("rst_mem_data", 64'(sb.mem_writeData), 64'd0);
    rst_n = 1'b1;
    tick();
    push(32'd5, 32'hAAAA5555);
    tick();
    chk("single_empty", 64'(sb.empty), 64'd1);
    sb.mem_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(32'(i), 32'h100 + 32'(i));
    chk("full_count", 64'(sb.count), 64'd4);
    chk("full_ready", 64'(sb.st_ready), 64'd0);
    sb.st_valid = 1'b1;
    sb.st_addr = 32'd9;
    sb.st_data = 32'hDEAD;
    repeat (3) tick();
    chk("full_reject_count", 64'(sb.count), 64'd4);
    sb.st_valid = 1'b0;
    sb.mem_hold = 1'b0;
    repeat (4) tick();
    chk("four_cycle_drain", 64'(sb.empty), 64'd1);
    sb.mem_hold = 1'b1;
    push(32'd7, 32'h11);
    push(32'd7, 32'h22);
    sb.ld_addr = 32'd7;
    #1;
    chk("fwd_hit", 64'(sb.ld_hit), 64'd1);
    chk("fwd_youngest", 64'(sb.ld_fwd_data), 64'h22);
    sb.ld_addr = 32'd8;
    #1;
    chk("fwd_miss", 64'(sb.ld_hit), 64'd0);
    chk("fwd_miss_data", 64'(sb.ld_fwd_data), 64'd0);
    sb.st_valid = 1'b1;
    sb.st_addr = 32'd9;
    sb.st_data = 32'h99;
    sb.ld_addr = 32'd9;
    @(negedge clk);
    chk("fwd_no_push_bypass", 64'(sb.ld_hit), 64'd0);
    tick();
    sb.st_valid = 1'b0;
    exp_q.push_back('{addr: 32'd9, data: 32'h99});
    chk("fwd_after_push", 64'(sb.ld_fwd_data), 64'h99);
    sb.mem_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fwd_during_drain", 64'(sb.ld_hit), 64'd1);
      chk("fwd_during_drain_data", 64'(sb.ld_fwd_data), 64'h99);
    end
    tick();
    chk("fwd_drained_empty", 64'(sb.empty), 64'd1);
    chk("fwd_drained_hit", 64'(sb.ld_hit), 64'd0);
    sb.mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h20 + 32'(i), 32'hC000 + 32'(i));
    sb.mem_hold = 1'b0;
    for (int i = 4; i < 10; i++) begin
      push(32'h20 + 32'(i), 32'hC000 + 32'(i));
      chk("stream_count_range", 64'(sb.count >= 3 && sb.count <= 4), 64'd1);
    end
    wait_empty();
    sb.mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h40 + 32'(i), 32'hE000 + 32'(i));
    chk("pre_reset_count", 64'(sb.count), 64'd3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.mem_hold = 1'b0;
    #1;
    exp_q.delete();
    chk("async_rst_count", 64'(sb.count), 64'd0);
    chk("async_rst_mem_write", 64'(sb.mem_write), 64'd0);
    chk("async_rst_empty", 64'(sb.empty), 64'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_reset_empty", 64'(sb.empty), 64'd1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
